// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the single-cycle core and its trace path.
//   REG_ADDR_W    - architectural register address width
//   CORE_PC_W     - default captured program-counter width
//   CORE_DATA_W   - default write-back data width
//   trace_entry_t - packed {pc, rd, data} record. The trace FIFO stores entries
//                   in this field order, and the trace UART decodes them the
//                   same way.
package core_pkg;

   localparam int REG_ADDR_W  = 5;
   localparam int CORE_PC_W   = 10;
   localparam int CORE_DATA_W = 32;

   typedef struct packed {
      logic [CORE_PC_W-1:0]   pc;
      logic [REG_ADDR_W-1:0]  rd;
      logic [CORE_DATA_W-1:0] data;
   } trace_entry_t;

endpackage

// File: rtl/wb_trace_ram.sv
// wb_trace_ram: DEPTH x W register array with one synchronous write port and
// one asynchronous read port. The contents are not reset.
//   clk   - write clock
//   we    - write enable; wdata is stored at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - combinational read of the entry at raddr
module wb_trace_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 47
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures {pc, rd, data} for every committed register write
// into a first-word-fall-through circular FIFO. A host drains the FIFO over a
// valid/ready stream. The block never stalls the core. A capture that arrives
// while the FIFO is full, with no pop in the same cycle, is dropped. Each drop
// sets the sticky overflow flag and increments the saturating drop_cnt.
//   clk, reset         - clock; asynchronous active-low reset
//   cap_en/pc/rd/data  - capture strobe and the fields of the write-back
//   flush              - synchronous clear of the contents and the overflow
//                        flag; drop_cnt keeps its value
//   out_valid/ready    - drain handshake
//   out_pc/rd/data     - head entry; these outputs are 0 when the FIFO is empty
//   count              - occupancy, 0..DEPTH
//   overflow, drop_cnt - loss reporting
// Build option: WBTRACE_SKIP_R0_EN. When defined, the block ignores captures
// whose destination is x0. Those captures are neither pushed nor counted as
// drops.
module wb_trace_fifo
   import core_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int PC_W   = CORE_PC_W,
   parameter int DATA_W = CORE_DATA_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cap_en,
   input  logic [PC_W-1:0]          cap_pc,
   input  logic [REG_ADDR_W-1:0]    cap_rd,
   input  logic [DATA_W-1:0]        cap_data,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [REG_ADDR_W-1:0]    out_rd,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [15:0]              drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = PC_W + REG_ADDR_W + DATA_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          cap_req, full, push, pop, drop;
   logic [EW-1:0] wr_entry, rd_entry;

`ifdef WBTRACE_SKIP_R0_EN
   // Writes to x0 have no architectural effect, so they are not traced.
   assign cap_req = cap_en && (cap_rd != '0);
`else
   assign cap_req = cap_en;
`endif

   assign full      = (count == FULL_CNT);
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   // At full, a pop in the same cycle frees the slot this push writes.
   assign push      = cap_req && (!full || pop);
   assign drop      = cap_req && full && !pop;

   assign wr_entry = {cap_pc, cap_rd, cap_data};

   // Flush discards a push in the same cycle, so that push must not write.
   wb_trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk   (clk),
      .we    (push && !flush),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // The read path runs from registered pointers to the array only, so there
   // is no combinational path from cap_* to out_*. Stale contents are masked
   // while the FIFO is empty.
   assign out_pc   = out_valid ? rd_entry[EW-1 -: PC_W]              : '0;
   assign out_rd   = out_valid ? rd_entry[DATA_W +: REG_ADDR_W]      : '0;
   assign out_data = out_valid ? rd_entry[DATA_W-1:0]                : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         // DEPTH is a power of two, so the natural pointer wrap is modulo DEPTH.
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: directed checks of wb_trace_fifo at DEPTH=16. The bench
// drives inputs and samples outputs 1 time unit after each rising edge.
module tb_wb_trace_fifo;
   import core_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cap_en = 1'b0;
   logic [9:0]  cap_pc = '0;
   logic [4:0]  cap_rd = '0;
   logic [31:0] cap_data = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [9:0]  out_pc;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [4:0]  count;
   logic        overflow;
   logic [15:0] drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_trace_fifo #(.DEPTH(16), .PC_W(10), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .cap_en(cap_en), .cap_pc(cap_pc),
      .cap_rd(cap_rd), .cap_data(cap_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rd(out_rd), .out_data(out_data), .count(count),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [9:0] pc, input logic [4:0] rd, input logic [31:0] d);
      cap_en = 1'b1; cap_pc = pc; cap_rd = rd; cap_data = d;
      step();
      cap_en = 1'b0;
   endtask

   initial begin
      int k;
      logic [0:5] rdy_pat;

      // Reset state
      #2;
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_data", out_data, 0);
      #10 reset = 1'b1;
      step();

      // Single capture, 1-cycle latency
      push_one(10'h004, 5'd8, 32'h5);
      chk("t1_valid", out_valid, 1);
      chk("t1_pc", out_pc, 10'h004);
      chk("t1_rd", out_rd, 8);
      chk("t1_data", out_data, 5);
      chk("t1_count", count, 1);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("t1_empty_cnt", count, 0);
      chk("t1_empty_vld", out_valid, 0);
      chk("t1_empty_data", out_data, 0);

      // Fill plus three dropped captures
      for (int i = 0; i < 16; i++) push_one(10'(i), 5'(i + 1), 32'h100 + i);
      for (int i = 0; i < 3; i++)  push_one(10'h3F0 + 10'(i), 5'd31, 32'hDEAD);
      chk("t2_count", count, 16);
      chk("t2_ovf", overflow, 1);
      chk("t2_drop", drop_cnt, 3);
      chk("t2_head_pc", out_pc, 0);
      chk("t2_head_data", out_data, 32'h100);

      // Push and pop together at full
      cap_en = 1'b1; cap_pc = 10'h200; cap_rd = 5'd17; cap_data = 32'hABCD;
      out_ready = 1'b1;
      step();
      cap_en = 1'b0; out_ready = 1'b0;
      chk("t3_count", count, 16);
      chk("t3_drop", drop_cnt, 3);
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("t3_pc%0d", i), out_pc, 10'(i));
         chk($sformatf("t3_data%0d", i), out_data, 32'h100 + i);
         out_ready = 1'b1; step(); out_ready = 1'b0;
      end
      chk("t3_wrap_pc", out_pc, 10'h200);
      chk("t3_wrap_rd", out_rd, 17);
      chk("t3_wrap_data", out_data, 32'hABCD);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("t3_end_cnt", count, 0);

      // Backpressure
      for (int i = 0; i < 4; i++) push_one(10'h010 + 10'(i), 5'd3, 32'hD0 + i);
      rdy_pat = 6'b100111;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("t4_vld%0d", i), out_valid, 1);
         chk($sformatf("t4_pc%0d", i), out_pc, 10'h010 + 10'(k));
         chk($sformatf("t4_data%0d", i), out_data, 32'hD0 + k);
         out_ready = rdy_pat[i];
         step();
         if (rdy_pat[i]) k++;
      end
      out_ready = 1'b0;
      chk("t4_vld_end", out_valid, 0);
      chk("t4_cnt_end", count, 0);

      // Async reset mid-stream
      push_one(10'h055, 5'd4, 32'h55);
      push_one(10'h056, 5'd4, 32'h56);
      reset = 1'b0;
      #2;
      chk("t5_rst_cnt", count, 0);
      chk("t5_rst_vld", out_valid, 0);
      chk("t5_rst_drop", drop_cnt, 0);
      chk("t5_rst_ovf", overflow, 0);
      chk("t5_rst_pc", out_pc, 0);
      reset = 1'b1;

      // Flush with 5 entries queued and drop_cnt=2
      for (int i = 0; i < 18; i++) push_one(10'h080 + 10'(i), 5'd6, 32'h80 + i);
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) step();
      out_ready = 1'b0;
      chk("t5_pre_cnt", count, 5);
      chk("t5_pre_drop", drop_cnt, 2);
      chk("t5_pre_ovf", overflow, 1);
      flush = 1'b1; cap_en = 1'b1; cap_rd = 5'd9; out_ready = 1'b1;
      step();
      flush = 1'b0; cap_en = 1'b0; out_ready = 1'b0;
      chk("t5_fl_cnt", count, 0);
      chk("t5_fl_vld", out_valid, 0);
      chk("t5_fl_ovf", overflow, 0);
      chk("t5_fl_drop", drop_cnt, 2);
      step();
      chk("t5_fl_cnt2", count, 0);

      // Captures to x0 and x2
      push_one(10'h0A0, 5'd0, 32'hA0);
      push_one(10'h0A2, 5'd2, 32'hA2);
`ifdef WBTRACE_SKIP_R0_EN
      chk("t6_count", count, 1);
      chk("t6_head_rd", out_rd, 2);
      chk("t6_drop", drop_cnt, 2);
`else
      chk("t6_count", count, 2);
      chk("t6_head_rd", out_rd, 0);
      out_ready = 1'b1; step(); out_ready = 1'b0;
      chk("t6_next_rd", out_rd, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule

// File: doc/wb_trace_fifo.md
Name: wb_trace_fifo

Overview:
- Downstream consumer of the single-cycle datapath's write-back result.
- Every cycle the core commits a register write, the block captures {pc, destination register, write-back data} into a circular FIFO.
- A host (debug UART, testbench scoreboard) drains the FIFO over a valid/ready stream.
- Decouples the one-instruction-per-clock core from a slower trace consumer and never stalls the core: overflow drops entries and records the loss.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 2..256.
- PC_W, 10, width of captured program counter.
- DATA_W, 32, width of captured write-back data.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- cap_en  input  1  capture strobe; tie to core reg_write.
- cap_pc  input  PC_W  pc of committing instruction.
- cap_rd  input  5  destination register address (write_reg_addr).
- cap_data  input  DATA_W  write-back data (datapath_result).
- flush  input  1  synchronous clear of FIFO contents, excluding drop counter.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head this cycle.
- out_pc  output  PC_W  head entry pc.
- out_rd  output  5  head entry destination register.
- out_data  output  DATA_W  head entry data.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one capture dropped since reset/flush.
- drop_cnt  output  16  saturating count of dropped captures.

Behaviour:
- Reset (reset==0, async):
  - rd_ptr=0, wr_ptr=0, count=0, out_valid=0, overflow=0, drop_cnt=0.
  - out_pc, out_rd, out_data=0.
  - Storage array contents are don't-care.
- Pointers:
  - Width $clog2(DEPTH); wrap modulo DEPTH.
  - Full when count==DEPTH; empty when count==0.
- push = cap_en && (count<DEPTH || pop). Entry is written at wr_ptr; wr_ptr increments.
- pop = out_valid && out_ready. rd_ptr increments.
- Simultaneous push and pop:
  - count unchanged.
  - At full, the push is accepted because the pop frees the slot in the same edge.
- Capture while full without pop: entry dropped; overflow<=1; drop_cnt increments, saturating at 16'hFFFF.
- Output timing:
  - First-word-fall-through: out_valid = (count!=0).
  - out_* reflect the array entry at rd_ptr.
  - Latency from capture edge to out_valid=1 is 1 clock.
  - When count==0, out_pc/out_rd/out_data are driven 0.
- Stream rules:
  - out_* stay stable while out_valid && !out_ready.
  - out_ready while !out_valid has no effect.
- flush==1:
  - Next edge: rd_ptr=wr_ptr=0, count=0, overflow=0.
  - Any push or pop in that same cycle is discarded.
  - drop_cnt is retained.
- Reset asserted mid-drain returns immediately to the reset state; no partial entry survives.
- No combinational path from cap_* to out_*.

Optional Feature:
- Macro WBTRACE_SKIP_R0_EN.
- Defined: captures with cap_rd==5'd0 are ignored entirely. Writes to $zero have no architectural effect, so these are not pushed and are never counted as drops.
- Undefined: every cap_en capture is treated identically regardless of cap_rd.

Decomposition:
- Shared package (core_pkg):
  - REG_ADDR_W=5.
  - Default PC_W/DATA_W constants.
  - Packed typedef trace_entry_t {pc, rd, data}, used by this block and the future trace UART.
- One natural sub-module: wb_trace_ram, a DEPTH x entry-width register array with one synchronous write port and an asynchronous read port.
- Pointer/count/flag logic stays in the top.

Test Plan:
- Reset then single capture:
  - Stimulus: cap_en=1, pc=0x004, rd=8, data=0x0000_0005, out_ready=0.
  - Response: next cycle out_valid=1, out_pc=0x004, out_rd=8, out_data=5, count=1.
- Fill to DEPTH=16 with out_ready=0, then 3 more captures:
  - count=16, overflow=1, drop_cnt=3.
  - Draining yields the first 16 entries in order.
- Full FIFO with cap_en=1 and out_ready=1 in the same cycle:
  - Head popped, new entry accepted, count stays 16, drop_cnt unchanged.
  - Pointers wrap correctly (entry 17 read back after 15 more pops).
- Backpressure:
  - Stimulus: 4 entries queued, out_ready toggles 1,0,0,1,1,1.
  - Response: out_* held stable during the 0 cycles; 4 pops in order; out_valid=0 after; count=0.
- Flush with 5 entries and drop_cnt=2:
  - Next cycle count=0, out_valid=0, overflow=0, drop_cnt=2.
  - Reset low mid-stream clears drop_cnt to 0 asynchronously.
- With WBTRACE_SKIP_R0_EN defined:
  - Stimulus: captures to rd=0 and rd=2.
  - Response: only the rd=2 entry appears, count=1.
  - Without the macro, both appear, count=2.
